// File: rtl/mpc_types_pkg.sv
// Shared write-buffer types: per-entry lifecycle state and the depth ceiling.
package mpc_types;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ALLOC  = 2'd1,
        FILLED = 2'd2
    } wbuf_state_e;

    localparam int WBUF_MAX_DEPTH = 64;

endpackage

// File: rtl/wbuf_merge_entry.sv
// One write-buffer entry: lifecycle state, data register and byte-masked merge.
// merged_o is the current data with this cycle's beat applied. The top level
// uses it only when the read/last-beat bypass is enabled.
module wbuf_merge_entry
    import mpc_types::*;
#(
    parameter int DATA_W = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_i,
    input  logic                wr_en_i,
    input  logic                wr_last_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic                rel_i,
    output logic                is_free_o,
    output logic                is_alloc_o,
    output logic                is_filled_o,
    output logic [DATA_W-1:0]   data_o,
    output logic [DATA_W-1:0]   merged_o
);
    localparam int BE_W = DATA_W / 8;

    wbuf_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_data;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) r[8*k +: 8] = new_data[8*k +: 8];
        end
        return r;
    endfunction

    assign merged_o    = byte_merge(data_q, wr_data_i, wr_be_i);
    assign data_o      = data_q;
    assign is_free_o   = (state_q == FREE);
    assign is_alloc_o  = (state_q == ALLOC);
    assign is_filled_o = (state_q == FILLED);

    // Next-state and data update; a release in ALLOC only occurs on the bypass path.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            FREE: begin
                if (alloc_i) begin
                    state_d = ALLOC;
                    data_d  = '0;
                end
            end
            ALLOC: begin
                if (wr_en_i) begin
                    data_d = merged_o;
                    if (wr_last_i) state_d = FILLED;
                end
                if (rel_i) state_d = FREE;
            end
            FILLED: begin
                if (rel_i) state_d = FREE;
            end
            default: state_d = FREE;
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FREE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/wbuf_merge_buffer.sv
// Write merge buffer: self-allocating entries, byte-masked beat merge and
// indexed reads with optional release.
// Optional feature macro: MPC_WBUF_BYPASS_EN. When it is defined, a read that
// coincides with the last beat of an ALLOC entry sees the merged data.
module wbuf_merge_buffer
    import mpc_types::*;
#(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 8,
    localparam int ID_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_req,
    output logic                alloc_gnt,
    output logic [ID_W-1:0]     alloc_id,
    input  logic                wr_valid,
    input  logic [ID_W-1:0]     wr_id,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                wr_last,
    output logic                wr_err,
    input  logic                rd_valid,
    input  logic [ID_W-1:0]     rd_id,
    input  logic                rd_release,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                free_valid,
    output logic [ID_W-1:0]     free_id,
    output logic [ID_W:0]       count,
    output logic                full,
    output logic                empty
);
    localparam int CNT_W = ID_W + 1;

    if (DEPTH < 2 || DEPTH > WBUF_MAX_DEPTH) begin : g_bad_depth
        $error("wbuf_merge_buffer: DEPTH out of range");
    end

    logic [DEPTH-1:0]  is_free, is_alloc, is_filled;
    logic [DEPTH-1:0]  alloc_oh, ent_alloc, ent_wr, ent_rel, wr_sel, rd_sel;
    logic [DATA_W-1:0] ent_data   [DEPTH];
    logic [DATA_W-1:0] ent_merged [DEPTH];
    logic              wr_in_range, rd_in_range, wr_hit, rd_filled, byp_hit, rd_ok, rel;
    logic [DATA_W-1:0] rd_word;

    logic [CNT_W-1:0]  count_q, count_d;
    logic              rsp_valid_q, rsp_err_q, wr_err_q, free_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ID_W-1:0]   free_id_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        wbuf_merge_entry #(.DATA_W(DATA_W)) u_ent (
            .clk        (clk),
            .rst_n      (rst_n),
            .alloc_i    (ent_alloc[g]),
            .wr_en_i    (ent_wr[g]),
            .wr_last_i  (wr_last),
            .wr_data_i  (wr_data),
            .wr_be_i    (wr_be),
            .rel_i      (ent_rel[g]),
            .is_free_o  (is_free[g]),
            .is_alloc_o (is_alloc[g]),
            .is_filled_o(is_filled[g]),
            .data_o     (ent_data[g]),
            .merged_o   (ent_merged[g])
        );
    end

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign alloc_gnt = alloc_req & ~full;
    assign ent_alloc = alloc_gnt ? alloc_oh : '0;

    // Lowest-index free entry; scanning downward leaves the lowest hit last.
    always_comb begin
        alloc_id = '0;
        alloc_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (is_free[i]) begin
                alloc_id    = ID_W'(i);
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
    end

    assign wr_in_range = ({1'b0, wr_id} < CNT_W'(DEPTH));
    assign rd_in_range = ({1'b0, rd_id} < CNT_W'(DEPTH));

    // One-hot decode of the write and read targets; out-of-range IDs select nothing.
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i] = wr_in_range && (wr_id == ID_W'(i));
            rd_sel[i] = rd_in_range && (rd_id == ID_W'(i));
        end
    end

    assign wr_hit    = wr_valid & (|(wr_sel & is_alloc));
    assign ent_wr    = wr_valid ? (wr_sel & is_alloc) : '0;
    assign rd_filled = rd_valid & (|(rd_sel & is_filled));
`ifdef MPC_WBUF_BYPASS_EN
    assign byp_hit   = rd_valid & wr_valid & wr_last & (|(rd_sel & wr_sel & is_alloc));
`else
    assign byp_hit   = 1'b0;
`endif
    assign rd_ok     = rd_filled | byp_hit;
    assign rel       = rd_ok & rd_release;
    assign ent_rel   = rel ? rd_sel : '0;
    assign count_d   = count_q + CNT_W'(alloc_gnt) - CNT_W'(rel);

    // One-hot read mux; the bypass path picks the post-beat data.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_sel[i]) rd_word = rd_word | (byp_hit ? ent_merged[i] : ent_data[i]);
        end
    end

    // Occupancy count and the registered response / error / release pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            wr_err_q     <= 1'b0;
            free_valid_q <= 1'b0;
            free_id_q    <= '0;
        end else begin
            count_q      <= count_d;
            rsp_valid_q  <= rd_valid;
            rsp_err_q    <= rd_valid & ~rd_ok;
            rsp_data_q   <= rd_ok ? rd_word : '0;
            wr_err_q     <= wr_valid & ~wr_hit;
            free_valid_q <= rel;
            free_id_q    <= rel ? rd_id : '0;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;
    assign wr_err     = wr_err_q;
    assign free_valid = free_valid_q;
    assign free_id    = free_id_q;

endmodule

// File: tb/tb_wbuf_merge_buffer.sv
// Bench for wbuf_merge_buffer: directed scenarios plus random traffic checked
// against an entry-level reference model.
module tb_wbuf_merge_buffer;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 8;
    localparam int ID_W   = 3;
    localparam int BE_W   = DATA_W / 8;
    localparam int W      = DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              alloc_req = 1'b0;
    logic              alloc_gnt;
    logic [ID_W-1:0]   alloc_id;
    logic              wr_valid = 1'b0;
    logic [ID_W-1:0]   wr_id = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [BE_W-1:0]   wr_be = '0;
    logic              wr_last = 1'b0;
    logic              wr_err;
    logic              rd_valid = 1'b0;
    logic [ID_W-1:0]   rd_id = '0;
    logic              rd_release = 1'b0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              free_valid;
    logic [ID_W-1:0]   free_id;
    logic [ID_W:0]     count;
    logic              full;
    logic              empty;

    wbuf_merge_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
        .wr_valid(wr_valid), .wr_id(wr_id), .wr_data(wr_data), .wr_be(wr_be),
        .wr_last(wr_last), .wr_err(wr_err),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_release(rd_release),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .free_valid(free_valid), .free_id(free_id),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: 0 = free, 1 = allocated, 2 = filled.
    int                mst  [DEPTH];
    logic [DATA_W-1:0] mdat [DEPTH];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mst[i]  = 0;
            mdat[i] = '0;
        end
    endtask

    task automatic idle();
        alloc_req  = 1'b0;
        wr_valid   = 1'b0;
        wr_id      = '0;
        wr_data    = '0;
        wr_be      = '0;
        wr_last    = 1'b0;
        rd_valid   = 1'b0;
        rd_id      = '0;
        rd_release = 1'b0;
    endtask

    // One cycle with the currently driven inputs, checked against the model.
    task automatic tick();
        int                cnt, aid;
        bit                gnt, wok, rfill, byp, rok, rel;
        logic [DATA_W-1:0] merged, exp_data;
        @(negedge clk);
        cnt = 0;
        aid = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mst[i] != 0) cnt++;
            else if (aid < 0) aid = i;
        end
        if (aid < 0) aid = 0;
        gnt = alloc_req && (cnt < DEPTH);
        chk("alloc_gnt", W'(alloc_gnt), W'(gnt));
        if (gnt) chk("alloc_id", W'(alloc_id), W'(aid));
        chk("count", W'(count), W'(cnt));
        chk("full", W'(full), W'(cnt == DEPTH));
        chk("empty", W'(empty), W'(cnt == 0));

        wok    = wr_valid && (mst[wr_id] == 1);
        merged = mdat[wr_id];
        for (int k = 0; k < BE_W; k++) begin
            if (wr_be[k]) merged[8*k +: 8] = wr_data[8*k +: 8];
        end
        rfill = rd_valid && (mst[rd_id] == 2);
        byp   = 1'b0;
`ifdef MPC_WBUF_BYPASS_EN
        byp   = rd_valid && wok && wr_last && (wr_id == rd_id);
`endif
        rok      = rfill || byp;
        rel      = rok && rd_release;
        exp_data = rfill ? mdat[rd_id] : (byp ? merged : '0);

        @(posedge clk);
        #1;
        chk("rsp_valid", W'(rsp_valid), W'(rd_valid));
        if (rd_valid) begin
            chk("rsp_err", W'(rsp_err), W'(!rok));
            chk("rsp_data", rsp_data, exp_data);
        end
        chk("wr_err", W'(wr_err), W'(wr_valid && !wok));
        chk("free_valid", W'(free_valid), W'(rel));
        if (rel) chk("free_id", W'(free_id), W'(rd_id));

        if (gnt) begin
            mst[aid]  = 1;
            mdat[aid] = '0;
        end
        if (wok) begin
            mdat[wr_id] = merged;
            if (wr_last) mst[wr_id] = 2;
        end
        if (rel) mst[rd_id] = 0;
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            alloc_req  = ($urandom_range(0, 1) == 1);
            wr_valid   = ($urandom_range(0, 9) < 6);
            wr_id      = ID_W'($urandom);
            wr_data    = {$urandom, $urandom, $urandom, $urandom};
            wr_be      = BE_W'($urandom);
            wr_last    = ($urandom_range(0, 9) < 3);
            rd_valid   = ($urandom_range(0, 1) == 1);
            rd_id      = ($urandom_range(0, 3) == 0) ? wr_id : ID_W'($urandom);
            rd_release = ($urandom_range(0, 1) == 1);
            tick();
        end
        idle();
    endtask

    logic [DATA_W-1:0] rnd;

    initial begin
        // Reset state.
        idle();
        model_reset();
        #2;
        alloc_req = 1'b1;
        #1;
        chk("rst_gnt", W'(alloc_gnt), W'(1'b1));
        chk("rst_count", W'(count), W'(0));
        chk("rst_empty", W'(empty), W'(1'b1));
        chk("rst_full", W'(full), W'(1'b0));
        chk("rst_rsp_valid", W'(rsp_valid), W'(1'b0));
        chk("rst_rsp_data", rsp_data, W'(0));
        chk("rst_wr_err", W'(wr_err), W'(1'b0));
        chk("rst_free_valid", W'(free_valid), W'(1'b0));
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill all entries in order.
        for (int i = 0; i < DEPTH; i++) begin
            alloc_req = 1'b1;
            #1;
            chk("plan_alloc_id", W'(alloc_id), W'(i));
            tick();
        end
        chk("plan_full", W'(full), W'(1'b1));
        alloc_req = 1'b1;
        #1;
        chk("plan_gnt_full", W'(alloc_gnt), W'(1'b0));
        tick();

        // Two-beat merge into entry 3, then read it.
        idle();
        wr_valid = 1'b1; wr_id = 3'd3; wr_data = W'(32'h11223344); wr_be = 16'h000F;
        tick();
        wr_data = W'(32'hAABBCCDD) << 96; wr_be = 16'hF000; wr_last = 1'b1;
        tick();
        idle();
        rd_valid = 1'b1; rd_id = 3'd3;
        tick();
        chk("plan_rd3", rsp_data, 128'hAABBCCDD_00000000_00000000_11223344);
        chk("plan_rd3_err", W'(rsp_err), W'(1'b0));
        rd_release = 1'b1;
        tick();
        chk("plan_free_valid", W'(free_valid), W'(1'b1));
        chk("plan_free_id", W'(free_id), W'(3));
        chk("plan_count7", W'(count), W'(7));
        idle();
        alloc_req = 1'b1;
        #1;
        chk("plan_realloc3", W'(alloc_id), W'(3));
        tick();

        // Full buffer: release entry 0 while requesting allocation.
        idle();
        wr_valid = 1'b1; wr_id = 3'd0; wr_last = 1'b1; wr_be = '0;
        tick();
        idle();
        alloc_req = 1'b1; rd_valid = 1'b1; rd_id = 3'd0; rd_release = 1'b1;
        #1;
        chk("plan_gnt_rel", W'(alloc_gnt), W'(1'b0));
        tick();
        idle();
        alloc_req = 1'b1;
        #1;
        chk("plan_gnt_next", W'(alloc_gnt), W'(1'b1));
        chk("plan_id0", W'(alloc_id), W'(0));
        tick();
        chk("plan_count8", W'(count), W'(8));

        // Write and read to a free entry 5.
        idle();
        wr_valid = 1'b1; wr_id = 3'd5; wr_last = 1'b1; wr_be = '1;
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        idle();
        rd_valid = 1'b1; rd_id = 3'd5; rd_release = 1'b1;
        tick();
        idle();
        wr_valid = 1'b1; wr_id = 3'd5; wr_be = '1; wr_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        chk("plan_wr_err5", W'(wr_err), W'(1'b1));
        idle();
        rd_valid = 1'b1; rd_id = 3'd5;
        tick();
        chk("plan_rd5_err", W'(rsp_err), W'(1'b1));
        chk("plan_rd5_data", rsp_data, W'(0));

        // Last beat and read of entry 2 in the same cycle.
        idle();
        rnd = {$urandom, $urandom, $urandom, $urandom};
        wr_valid = 1'b1; wr_id = 3'd2; wr_last = 1'b1; wr_be = '1; wr_data = rnd;
        rd_valid = 1'b1; rd_id = 3'd2;
        tick();
`ifdef MPC_WBUF_BYPASS_EN
        chk("plan_byp_err", W'(rsp_err), W'(1'b0));
        chk("plan_byp_data", rsp_data, rnd);
`else
        chk("plan_nobyp_err", W'(rsp_err), W'(1'b1));
`endif
        idle();

        // Random traffic.
        rand_cycles(400);

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", W'(count), W'(0));
        chk("mid_rst_empty", W'(empty), W'(1'b1));
        chk("mid_rst_rsp_valid", W'(rsp_valid), W'(1'b0));
        chk("mid_rst_wr_err", W'(wr_err), W'(1'b0));
        chk("mid_rst_free_valid", W'(free_valid), W'(1'b0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rand_cycles(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
